// File: rtl/seg_pkg.sv
// Shared constants and the hex-to-segment decode for the multiplexed display scanner.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF    = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// An input rising edge yields one 1-cycle pulse three clocks later.
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            pulse_q <= s2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/seg_scanner.sv
// Time-multiplexed seven-segment scanner: one digit per scan tick, with per-frame
// input shadowing, blink, and leading-zero blanking. All outputs are registered.
module seg_scanner #(
    parameter int unsigned NUM_DIGITS  = seg_pkg::NUM_DIGITS,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                    clk12Mhz,
    input  logic                    rst_n,
    input  logic                    clk1000hz,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic                    frame_start
);

    import seg_pkg::*;

    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic                    tick;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    running_q;
    logic [BW-1:0]           blink_cnt_q;
    logic                    phase_off_q;
    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   dp_q, en_q, blk_q;
    logic                    lz_q;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    seg_dp_q, seg_dp_d;
    logic                    frame_start_q;

    logic                    wrap;
    logic [4*NUM_DIGITS-1:0] eff_val;
    logic [NUM_DIGITS-1:0]   eff_dp, eff_en, eff_blk;
    logic                    eff_lz;
    logic [3:0]              nib;
    logic                    upper_zero;
    logic                    lead_zero;
    logic                    blank;

    edge_sync u_edge_sync (
        .clk_i   (clk12Mhz),
        .rst_ni  (rst_n),
        .d_i     (clk1000hz),
        .pulse_o (tick)
    );

    // The first tick after reset always starts a fresh frame at digit 0.
    assign wrap  = !running_q || (idx_q == IW'(NUM_DIGITS - 1));
    assign idx_d = wrap ? '0 : idx_q + IW'(1);

    // On a wrap tick the shadows are being loaded this edge, so decode from the live inputs.
    assign eff_val = wrap ? value    : val_q;
    assign eff_dp  = wrap ? dp       : dp_q;
    assign eff_en  = wrap ? digit_en : en_q;
    assign eff_blk = wrap ? blink    : blk_q;
    assign eff_lz  = wrap ? lz_blank : lz_q;

    assign nib = eff_val[4*idx_d +: 4];

    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (i >= int'(idx_d) && eff_val[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign lead_zero = eff_lz && (idx_d != '0) && upper_zero;
    assign blank     = !eff_en[idx_d] || (eff_blk[idx_d] && phase_off_q) || lead_zero;

    assign an_d     = ~(NUM_DIGITS'(1) << idx_d);
    assign seg_d    = blank ? SEG_OFF : hex_to_seg(nib);
    assign seg_dp_d = blank | ~eff_dp[idx_d];

    always_ff @(posedge clk12Mhz or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            running_q     <= 1'b0;
            blink_cnt_q   <= '0;
            phase_off_q   <= 1'b0;
            val_q         <= '0;
            dp_q          <= '0;
            en_q          <= '0;
            blk_q         <= '0;
            lz_q          <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            seg_dp_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= tick && wrap;
            if (tick) begin
                idx_q     <= idx_d;
                running_q <= 1'b1;
                an_q      <= an_d;
                seg_q     <= seg_d;
                seg_dp_q  <= seg_dp_d;
                if (wrap) begin
                    val_q <= value;
                    dp_q  <= dp;
                    en_q  <= digit_en;
                    blk_q <= blink;
                    lz_q  <= lz_blank;
                end
                // Phase used for this tick is the pre-update one, so the first window shows.
                if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                    blink_cnt_q <= '0;
                    phase_off_q <= ~phase_off_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign seg_dp      = seg_dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scanner.sv
// Randomized bench for seg_scanner: a tick-count based reference model checked every
// cycle, plus literal expectations for the directed display scenarios.
module tb_seg_scanner;

    localparam int N  = 8;
    localparam int BT = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        clk1000hz = 1'b0;
    logic [31:0] value     = '0;
    logic [7:0]  dp        = '0;
    logic [7:0]  digit_en  = 8'hFF;
    logic [7:0]  blink     = '0;
    logic        lz_blank  = 1'b0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        seg_dp;
    logic        frame_start;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    seg_scanner #(.NUM_DIGITS(N), .BLINK_TICKS(BT)) dut (
        .clk12Mhz    (clk),
        .rst_n       (rst_n),
        .clk1000hz   (clk1000hz),
        .value       (value),
        .dp          (dp),
        .digit_en    (digit_en),
        .blink       (blink),
        .lz_blank    (lz_blank),
        .an          (an),
        .seg         (seg),
        .seg_dp      (seg_dp),
        .frame_start (frame_start)
    );

    initial forever #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: input samples history -> tick count -> digit, frame, blink window.
    logic [7:0]  exp_an  = 8'hFF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_dp  = 1'b1;
    logic        exp_fs  = 1'b0;
    logic [3:0]  hist    = '0;
    int          ticks   = 0;
    int          m_d;
    logic        m_tick, m_vis, m_blank;
    logic [31:0] sh_val;
    logic [7:0]  sh_dp, sh_en, sh_blk;
    logic        sh_lz;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ticks = 0; hist = '0;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
        end else begin
            m_tick = hist[2] & ~hist[3];
            hist   = {hist[2:0], clk1000hz};
            exp_fs = 1'b0;
            if (m_tick) begin
                ticks++;
                m_d = (ticks - 1) % N;
                if (m_d == 0) begin
                    sh_val = value; sh_dp = dp; sh_en = digit_en; sh_blk = blink; sh_lz = lz_blank;
                end
                m_vis   = (((ticks - 1) / BT) % 2) == 0;
                m_blank = !sh_en[m_d] || (sh_blk[m_d] && !m_vis) ||
                          (sh_lz && m_d > 0 && (sh_val >> (4 * m_d)) == 0);
                exp_an  = ~(8'd1 << m_d);
                exp_seg = m_blank ? 7'h7F : hex_tab[4'(sh_val >> (4 * m_d))];
                exp_dp  = m_blank ? 1'b1 : ~sh_dp[m_d];
                exp_fs  = (m_d == 0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("an", an, exp_an);
            check("seg", seg, exp_seg);
            check("seg_dp", seg_dp, exp_dp);
            check("frame_start", frame_start, exp_fs);
        end
    end

    // Scan-rate source: randomly jittered square wave, a few clocks per half-period.
    logic gen_en  = 1'b0;
    int   gen_cnt = 0;
    initial forever begin
        @(negedge clk);
        if (gen_en) begin
            if (gen_cnt <= 1) begin
                clk1000hz = ~clk1000hz;
                gen_cnt   = $urandom_range(10, 4);
            end else begin
                gen_cnt--;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_digit(input int d, input string name);
        logic [7:0] tgt;
        int k;
        tgt = ~(8'd1 << d);
        k = 0;
        while (an !== tgt && k < 600) begin
            @(negedge clk);
            k++;
        end
        check(name, an, tgt);
    endtask

    task automatic wait_fs(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_start !== 1'b1 && k < 1200);
        check(name, frame_start, 1);
        check({name, "_an"}, an, 8'hFE);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        cycles(3);
        chk_en = 1'b1;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'b1111111);
        check("rst_dp", seg_dp, 1);
        check("rst_fs", frame_start, 0);

        // Basic scan order and frame alignment.
        value = $urandom; dp = 8'($urandom);
        rst_n = 1'b1;
        gen_en = 1'b1;
        wait_fs("first_frame");
        for (int d = 1; d < N; d++) wait_digit(d, "scan_order");
        wait_fs("second_frame");

        // Leading-zero blanking on 0x000000B8.
        value = 32'h0000_00B8; dp = '0; lz_blank = 1'b1;
        wait_fs("lz_frame");
        check("lz_d0", seg, 7'b0000000);
        wait_digit(1, "lz_at1");
        check("lz_d1", seg, 7'b0000011);
        wait_digit(2, "lz_at2");
        check("lz_d2", seg, 7'b1111111);
        check("lz_d2_dp", seg_dp, 1);
        lz_blank = 1'b0;
        wait_fs("nolz_frame");
        wait_digit(2, "nolz_at2");
        check("nolz_d2", seg, 7'b1000000);

        // Mid-frame input change is deferred to the next frame.
        value = 32'h1111_1111;
        wait_fs("shadow_frame");
        wait_digit(3, "shadow_at3");
        value = 32'hFFFF_FFFF;
        wait_digit(5, "shadow_at5");
        check("shadow_d5", seg, 7'b1111001);
        wait_digit(7, "shadow_at7");
        check("shadow_d7", seg, 7'b1111001);
        wait_fs("shadow_next");
        check("shadow_new", seg, 7'b0001110);

        // Random traffic against the model.
        for (int it = 0; it < 60; it++) begin
            cycles($urandom_range(40, 5));
            case ($urandom_range(4, 0))
                0: value = $urandom >> $urandom_range(31, 0);
                1: dp = 8'($urandom);
                2: digit_en = 8'($urandom) | 8'($urandom);
                3: blink = 8'($urandom);
                default: lz_blank = 1'($urandom);
            endcase
        end

        // Blink phase is visible first after reset.
        gen_en = 1'b0; clk1000hz = 1'b0;
        #2 rst_n = 1'b0;
        cycles(3);
        value = 32'h8888_8888; dp = '0; digit_en = 8'hFF; blink = 8'h11; lz_blank = 1'b0;
        rst_n = 1'b1;
        gen_en = 1'b1;
        wait_digit(0, "blink_at0");
        check("blink_d0_vis", seg, 7'b0000000);
        wait_digit(4, "blink_at4");
        check("blink_d4_off", seg, 7'b1111111);

        // Async reset mid-scan with the scan input high, then a stalled input.
        blink = '0;
        wait_digit(5, "rst_at5");
        gen_en = 1'b0; clk1000hz = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("async_an", an, 8'hFF);
        check("async_seg", seg, 7'b1111111);
        check("async_fs", frame_start, 0);
        cycles(3);
        rst_n = 1'b1;
        cycles(6);
        check("release_an", an, 8'hFE);
        cycles(100);
        check("stall_an", an, 8'hFE);
        check("stall_fs", frame_start, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scanner.md
SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk12Mhz and rst_n.
REQ-002 Parameter NUM_DIGITS, default 8: number of multiplexed digits.
REQ-003 Parameter BLINK_TICKS, default 250: scan ticks per blink half-period, giving about 0.25 s.
REQ-004 clk12Mhz  in  1  system clock, 12 MHz.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 clk1000hz  in  1  scan-rate square wave from the clock divider, treated as data and never used as a clock.
REQ-007 value  in  4*NUM_DIGITS  hex nibbles; digit i is value[4i+3:4i]; digit 0 is the rightmost.
REQ-008 dp  in  NUM_DIGITS  decimal-point request per digit.
REQ-009 digit_en  in  NUM_DIGITS  per-digit enable.
REQ-010 blink  in  NUM_DIGITS  per-digit blink mask.
REQ-011 lz_blank  in  1  leading-zero blanking enable.
REQ-012 an  out  NUM_DIGITS  digit select, active-low, one-cold.
REQ-013 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 seg_dp  out  1  decimal point, active-low.
REQ-015 frame_start  out  1  one-cycle pulse when digit 0 becomes selected.

Function
REQ-016 clk1000hz SHALL pass through a 2-FF synchronizer and then a rising-edge detector; each input rising edge SHALL produce exactly one 1-cycle tick, 3 cycles after the edge.
REQ-017 Digit index idx SHALL advance by one on each tick and wrap from NUM_DIGITS-1 to 0.
REQ-018 Shadow copies of value, dp, digit_en, blink and lz_blank SHALL load only on the tick where idx wraps to 0; inputs changing mid-frame SHALL NOT affect the current frame.
REQ-019 an, seg, seg_dp and frame_start SHALL be registered and update one cycle after tick; they SHALL be held between ticks.
REQ-020 an SHALL be driven low only at bit idx; exactly one digit is selected at all times outside reset.
REQ-021 The hex decode SHALL use these seg patterns: 0=1000000, 1=1111001, 8=0000000, B=0000011, F=0001110; all 16 codes SHALL be defined.
REQ-022 A digit SHALL be blanked (seg=1111111, seg_dp=1) if any of the following holds:
- its digit_en bit is 0;
- its blink bit is 1 and the blink phase is off;
- it is a leading zero.
REQ-023 Leading zero: lz_blank=1, i>0, and nibbles i..NUM_DIGITS-1 are all zero; digit 0 SHALL never be leading-zero blanked.
REQ-024 The blink counter SHALL count ticks 0..BLINK_TICKS-1 and toggle the blink phase on wrap; the phase is visible after reset.
REQ-025 A blanked digit SHALL still have its an bit driven low so that scan timing stays uniform.
REQ-026 frame_start SHALL be 1 exactly in the cycle where an first shows digit 0 of a new frame.
REQ-027 If clk1000hz stops, outputs SHALL freeze on the current digit with no further ticks.

Reset
REQ-028 During reset the outputs SHALL take these values: an=all 1, seg=1111111, seg_dp=1, frame_start=0.
REQ-029 During reset idx, the blink counter, the synchronizer, the edge register and the shadows SHALL be 0, and the blink phase SHALL be visible.
REQ-030 Reset assertion mid-scan SHALL force the reset values immediately and asynchronously.
REQ-031 If clk1000hz is high at reset release, exactly one tick SHALL occur within 3 cycles.
REQ-032 The first tick after reset SHALL select digit 0 and load the shadows.

Structure
REQ-033 Package seg_pkg SHALL hold NUM_DIGITS, the SEG_OFF constant (1111111) and the hex-to-segment function or table.
REQ-034 Sub-module edge_sync (2-FF synchronizer plus rising-edge pulse) SHALL be instantiated once.

Verification
REQ-035 Reset, then drive clk1000hz at 1 kHz -> an cycles FE,FD,FB,...,7F,FE; frame_start pulses once per 8 ticks, aligned with an=FE.
REQ-036 value=0x0000_00B8, lz_blank=1 -> digit0 seg=0000000, digit1 seg=0000011, digits 2..7 seg=1111111; with lz_blank=0, digits 2..7 seg=1000000.
REQ-037 Change value from 0x11111111 to 0xFFFFFFFF while idx=3 -> digits 3..7 still show 1111001; the next frame shows 0001110.
REQ-038 blink=0x01, BLINK_TICKS=4 -> digit 0 is blank in alternate 4-tick windows and visible immediately after reset.
REQ-039 Assert rst_n at idx=5 while clk1000hz is high -> an=FF in the same cycle; after release, one tick occurs and an=FE.
REQ-040 Hold clk1000hz high for 100 cycles -> exactly one tick and no further idx change.
